serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 152 +++++++++++++++
 tb/tb_serial_subtractor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit-counter width; never less than one bit so the counter always exists.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrowout
);

  assign diff      = a ^ b ^ bin;
  assign borrowout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin over WIDTH cycles, LSB first.
// Optional signed overflow output enabled by SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] res_full;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             borrowout_q, borrowout_d;
  logic             bit_diff, bit_borrow;
  logic             load, last;

  full_subtractor u_fs (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .bin      (borrow_q),
    .diff     (bit_diff),
    .borrowout(bit_borrow)
  );

  assign load     = start && (state_q != SHIFT);
  assign last     = (state_q == SHIFT) && (cnt_q == LAST);
  assign res_full = {bit_diff, res_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Partial results live in res_q; diff only changes on the final shift.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    diff_d      = diff_q;
    borrowout_d = borrowout_q;
    if (load) begin
      a_d      = a;
      b_d      = b;
      borrow_d = bin;
      res_d    = '0;
      cnt_d    = '0;
    end else if (state_q == SHIFT) begin
      a_d      = {1'b0, a_q[WIDTH-1:1]};
      b_d      = {1'b0, b_q[WIDTH-1:1]};
      res_d    = res_full[WIDTH-1:1];
      borrow_d = bit_borrow;
      cnt_d    = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        diff_d      = res_full;
        borrowout_d = bit_borrow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      borrowout_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      diff_q      <= diff_d;
      borrowout_q <= borrowout_d;
    end
  end

  assign diff      = diff_q;
  assign borrowout = borrowout_q;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  // Operand sign bits are captured at load because the operand registers shift.
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, overflow_q, overflow_d;

  always_comb begin
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    overflow_d = overflow_q;
    if (load) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (last) begin
      overflow_d = (a_msb_q != b_msb_q) && (bit_diff != a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: transaction-level model plus directed vectors.
module tb_serial_subtractor;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, borrowout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         overflow;
`endif

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrowout(borrowout)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void ref_sub(input int x, input int y, input int bi,
                                  output int d, output int bo, output int ov);
    int sx, sy;
    d  = (x - y - bi) & MASK;
    bo = (x < y + bi) ? 1 : 0;
    sx = (x >> (W - 1)) & 1;
    sy = (y >> (W - 1)) & 1;
    ov = ((sx != sy) && (((d >> (W - 1)) & 1) != sx)) ? 1 : 0;
  endfunction

  // Model: an accepted start yields a result W cycles later, shown for one cycle.
  int m_rem, m_diff, m_bout, m_ovf, p_diff, p_bout, p_ovf;
  bit m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_done = 0; m_diff = 0; m_bout = 0; m_ovf = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1; m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_rem = W;
        ref_sub(int'(a), int'(b), int'(bin), p_diff, p_bout, p_ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", int'(busy), (m_rem > 0) ? 1 : 0);
      check("cyc_done", int'(done), int'(m_done));
      check("cyc_diff", int'(diff), m_diff);
      check("cyc_borrowout", int'(borrowout), m_bout);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      check("cyc_overflow", int'(overflow), m_ovf);
`endif
    end
  end

  task automatic applyStimulus(input int x, input int y, input int bi);
    @(negedge clk);
    a = W'(x); b = W'(y); bin = 1'(bi); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Latency is counted in edges after the start-sampling edge (that edge is edge 1).
  task automatic checkOutput(input string name, input int exp_d, input int exp_bo, input int exp_lat);
    int edges = 0;
    int busy_cycles = 0;
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1 edges++;
      if (done) seen = 1;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, "_latency"}, edges, exp_lat);
      check({name, "_busy_cycles"}, busy_cycles, W);
      check({name, "_diff"}, int'(diff), exp_d);
      check({name, "_borrowout"}, int'(borrowout), exp_bo);
    end
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(posedge clk);
      #1 if (!busy && !done) idle = 1;
    end
    check("wait_idle", int'(idle), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, n_done;
    int done_at[3];

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_borrowout", int'(borrowout), 0);
    cmp_en = 1'b1;
    #2 rst_n = 1'b1;

    applyStimulus(9, 3, 0);
    checkOutput("sub_9_3", 6, 0, 4);
    applyStimulus(3, 9, 0);
    checkOutput("sub_3_9", 10, 1, 4);
    applyStimulus(0, 0, 1);
    checkOutput("sub_0_0_b1", 15, 1, 4);
    applyStimulus(15, 0, 0);
    checkOutput("sub_15_0", 15, 0, 4);
    applyStimulus(4, 4, 1);
    checkOutput("sub_4_4_b1", 15, 1, 4);
    applyStimulus(12, 5, 1);
    checkOutput("sub_12_5_b1", 6, 0, 4);
    waitIdle();

    // Back-to-back: start held high, DONE reloads straight into SHIFT.
    @(negedge clk);
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    cyc = 0; n_done = 0;
    for (int i = 0; i < 40 && n_done < 3; i++) begin
      @(posedge clk);
      #1 cyc++;
      if (done) begin
        done_at[n_done] = cyc;
        n_done++;
        check("b2b_diff", int'(diff), 5);
      end
    end
    start = 1'b0;
    check("b2b_done_count", n_done, 3);
    if (n_done == 3) begin
      check("b2b_first", done_at[0], 5);
      check("b2b_gap1", done_at[1] - done_at[0], 5);
      check("b2b_gap2", done_at[2] - done_at[1], 5);
    end
    waitIdle();

    // Start pulse during SHIFT must be ignored.
    applyStimulus(9, 3, 0);
    @(posedge clk);
    #1 a = 4'd1; b = 4'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = '0; b = '0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (done) begin
        n_done++;
        check("ignore_diff", int'(diff), 6);
      end
    end
    check("ignore_done_count", n_done, 1);
    check("ignore_diff_hold", int'(diff), 6);

    // Asynchronous reset in SHIFT cycle 2 aborts the operation.
    applyStimulus(9, 3, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_diff", int'(diff), 0);
    check("arst_borrowout", int'(borrowout), 0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (done) n_done++;
    end
    check("arst_no_done", n_done, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(5, 5, 0);
    checkOutput("post_rst_5_5", 0, 0, 4);

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    applyStimulus(8, 1, 0);
    checkOutput("ovf_8_1", 7, 0, 4);
    check("ovf_8_1_overflow", int'(overflow), 1);
    applyStimulus(6, 2, 0);
    checkOutput("ovf_6_2", 4, 0, 4);
    check("ovf_6_2_overflow", int'(overflow), 0);
`endif

    waitIdle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
